cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_ctrl_pkg.sv | 17 +
 rtl/debounce.sv | 42 ++++
 rtl/cpu_run_ctrl.sv | 97 +++++++++
 tb/tb_cpu_run_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared run-control state encoding for the CPU run controller and its users.
// Pure declarations; no logic, latency or flow control.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        RS_HALT = 2'd0,
        RS_RUN  = 2'd1,
        RS_STEP = 2'd2,
        RS_DONE = 2'd3
    } run_state_e;

    localparam logic [1:0] ST_HALT = RS_HALT;
    localparam logic [1:0] ST_RUN  = RS_RUN;
    localparam logic [1:0] ST_STEP = RS_STEP;
    localparam logic [1:0] ST_DONE = RS_DONE;

endpackage

// File: rtl/debounce.sv
// Button conditioner: 2-FF synchronizer, level debouncer, falling-edge one-shot.
// Latency: pulse 2 + DEBOUNCE_CYCLES cycles after the raw press settles.
// No backpressure: one pulse per accepted press, never queued.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic cpu_clk,
    input  logic resetN,
    input  logic btn_n,
    output logic pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level;
    logic [CW-1:0] cnt;

    // A new level is taken only after DEBOUNCE_CYCLES consecutive samples disagree with the current one.
    always_ff @(posedge cpu_clk or negedge resetN) begin
        if (!resetN) begin
            sync_q <= 2'b11;
            level  <= 1'b1;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_n};
            pulse  <= 1'b0;
            if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync_q[1];
                cnt   <= '0;
                pulse <= ~sync_q[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: run / single-step / breakpoint / done sequencing and instruction count.
// Latency: cpu_en is combinational from state and pc; state updates on the next cpu_clk edge.
// No backpressure: step presses outside HALT are dropped, not queued.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int                  PC_WIDTH        = 12,
    parameter logic [PC_WIDTH-1:0] FINAL_PC        = 12'hFFF,
    parameter int                  DEBOUNCE_CYCLES = 500000,
    parameter int                  AUTO_RUN        = 1,
    parameter int                  CNT_WIDTH       = 32
) (
    input  logic                 cpu_clk,
    input  logic                 resetN,
    input  logic                 mode_run,
    input  logic                 step_btnN,
    input  logic                 bp_enable,
    input  logic [PC_WIDTH-1:0]  bp_addr,
    input  logic [PC_WIDTH-1:0]  pc,
    output logic                 cpu_en,
    output logic                 halted,
    output logic                 finished,
    output logic [1:0]           state_o,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam logic [1:0] RESET_STATE = (AUTO_RUN != 0) ? ST_RUN : ST_HALT;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       skip;
    logic       step_pulse;
    logic       final_hit;
    logic       bp_hit;
    logic       en_raw;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .cpu_clk(cpu_clk),
        .resetN (resetN),
        .btn_n  (step_btnN),
        .pulse  (step_pulse)
    );

    assign final_hit = (pc == FINAL_PC);
    assign bp_hit    = bp_enable & (pc == bp_addr) & ~skip;

    always_comb begin
        en_raw = 1'b0;
        case (state)
            ST_RUN:  en_raw = mode_run & ~final_hit & ~bp_hit;
            ST_STEP: en_raw = ~final_hit;
            default: en_raw = 1'b0;
        endcase
    end

    // Reset gates the enable so an aborted RUN/STEP never leaks a clock-enable cycle.
    assign cpu_en   = resetN & en_raw;
    assign halted   = (state == ST_HALT);
    assign finished = (state == ST_DONE);
    assign state_o  = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (final_hit)     state_nxt = ST_DONE;
                else if (bp_hit)   state_nxt = ST_HALT;
                else if (!mode_run) state_nxt = ST_HALT;
            end
            ST_HALT: begin
                if (step_pulse) state_nxt = mode_run ? ST_RUN : ST_STEP;
            end
            ST_STEP: state_nxt = final_hit ? ST_DONE : ST_HALT;
            default: state_nxt = ST_DONE;
        endcase
    end

    // skip lets a resume from a breakpoint execute the breakpoint instruction once.
    always_ff @(posedge cpu_clk or negedge resetN) begin
        if (!resetN) begin
            state       <= RESET_STATE;
            skip        <= 1'b1;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_RUN && en_raw)
                skip <= 1'b0;
            else if (state == ST_HALT && step_pulse && mode_run)
                skip <= 1'b1;
            if (en_raw && (instr_count != '1))
                instr_count <= instr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_cpu_run_ctrl;

    localparam logic [11:0] FPC   = 12'h00F;
    localparam int          CW    = 5;
    localparam int          CMAX  = (1 << CW) - 1;
    localparam int          M_HALT = 0, M_RUN = 1, M_STEP = 2, M_DONE = 3;

    logic          cpu_clk = 1'b0;
    logic          resetN;
    logic          mode_run;
    logic          step_btnN;
    logic          bp_enable;
    logic [11:0]   bp_addr;
    logic [11:0]   pc;
    logic          cpu_en;
    logic          halted;
    logic          finished;
    logic [1:0]    state_o;
    logic [CW-1:0] instr_count;

    cpu_run_ctrl #(
        .PC_WIDTH(12), .FINAL_PC(FPC), .DEBOUNCE_CYCLES(4), .AUTO_RUN(1), .CNT_WIDTH(CW)
    ) dut (
        .cpu_clk(cpu_clk), .resetN(resetN), .mode_run(mode_run), .step_btnN(step_btnN),
        .bp_enable(bp_enable), .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en),
        .halted(halted), .finished(finished), .state_o(state_o), .instr_count(instr_count)
    );

    always #5 cpu_clk = ~cpu_clk;

    int vectors = 0;
    int miscompares = 0;
    int en_seen = 0;
    bit branch_en = 0;

    // Model state: run mode, skip flag, count, pending pulse, raw-button sample history.
    int m_state;
    bit m_skip;
    int m_count;
    bit m_pulse;
    bit m_level;
    bit h[6];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_RUN;
        m_skip  = 1'b1;
        m_count = 0;
        m_pulse = 1'b0;
        m_level = 1'b1;
        for (int i = 0; i < 6; i++) h[i] = 1'b1;
    endtask

    // One clock: check outputs against the model, advance the model, let the CPU fetch.
    task automatic cycle();
        bit fh, bh, en, dut_en;
        int nxt;
        #1;
        fh = (pc == FPC);
        bh = bp_enable && (pc == bp_addr) && !m_skip;
        if (m_state == M_RUN)       en = mode_run && !fh && !bh;
        else if (m_state == M_STEP) en = !fh;
        else                        en = 1'b0;
        check_val("cpu_en",      32'(cpu_en),      32'(en));
        check_val("halted",      32'(halted),      32'(m_state == M_HALT));
        check_val("finished",    32'(finished),    32'(m_state == M_DONE));
        check_val("state_o",     32'(state_o),     32'(m_state));
        check_val("instr_count", 32'(instr_count), 32'(m_count));
        dut_en = cpu_en;
        if (dut_en) en_seen++;

        nxt = m_state;
        case (m_state)
            M_RUN:  if (fh) nxt = M_DONE; else if (bh || !mode_run) nxt = M_HALT;
            M_HALT: if (m_pulse) begin
                        nxt = mode_run ? M_RUN : M_STEP;
                        if (mode_run) m_skip = 1'b1;
                    end
            M_STEP: nxt = fh ? M_DONE : M_HALT;
            default: nxt = M_DONE;
        endcase
        if (m_state == M_RUN && en) m_skip = 1'b0;
        if (en && m_count < CMAX) m_count++;
        m_state = nxt;

        // Debounced level flips once four synchronized samples in a row disagree with it.
        for (int i = 5; i > 0; i--) h[i] = h[i-1];
        h[0] = step_btnN;
        m_pulse = 1'b0;
        if (h[2] == h[3] && h[3] == h[4] && h[4] == h[5] && h[2] != m_level) begin
            m_level = h[2];
            m_pulse = !h[2];
        end

        @(posedge cpu_clk);
        #1;
        if (dut_en)
            pc = (branch_en && $urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 14)) : 12'(pc + 1);
        @(negedge cpu_clk);
    endtask

    task automatic do_reset(input bit mr);
        #2;
        resetN = 1'b0;
        #1;
        check_val("rst_cpu_en",   32'(cpu_en),      32'd0);
        check_val("rst_count",    32'(instr_count), 32'd0);
        check_val("rst_state",    32'(state_o),     32'(M_RUN));
        check_val("rst_halted",   32'(halted),      32'd0);
        check_val("rst_finished", 32'(finished),    32'd0);
        pc = '0;
        mode_run = mr;
        step_btnN = 1'b1;
        model_reset();
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        resetN = 1'b1;
    endtask

    task automatic press(input int low_cycles);
        step_btnN = 1'b0;
        repeat (low_cycles) cycle();
        step_btnN = 1'b1;
        repeat (8) cycle();
    endtask

    task automatic run_until_finished(input int bound);
        int k = 0;
        while (!finished && k < bound) begin
            cycle();
            k++;
        end
        check_val("finish_reached", 32'(finished), 32'd1);
    endtask

    initial begin
        int k;
        int run_left;
        int done_cnt;
        resetN = 1'b1; mode_run = 1'b1; step_btnN = 1'b1;
        bp_enable = 1'b0; bp_addr = '0; pc = '0;
        model_reset();
        @(negedge cpu_clk);

        // Free run to the final PC.
        do_reset(1'b1);
        en_seen = 0;
        run_until_finished(40);
        check_val("run_pc",     32'(pc),          32'h00F);
        check_val("run_count",  32'(instr_count), 32'd15);
        check_val("run_en_cyc", 32'(en_seen),     32'd15);

        // Breakpoint at 5, then resume to completion.
        do_reset(1'b1);
        bp_enable = 1'b1; bp_addr = 12'h005;
        k = 0;
        while (!halted && k < 40) begin cycle(); k++; end
        check_val("bp_halted", 32'(halted),      32'd1);
        check_val("bp_pc",     32'(pc),          32'h005);
        check_val("bp_count",  32'(instr_count), 32'd5);
        en_seen = 0;
        press(6);
        run_until_finished(40);
        check_val("bp_resume_en",  32'(en_seen),     32'd10);
        check_val("bp_final_pc",   32'(pc),          32'h00F);
        check_val("bp_final_cnt",  32'(instr_count), 32'd15);

        // Single-step three presses, then a short glitch.
        do_reset(1'b0);
        bp_enable = 1'b0;
        repeat (3) cycle();
        en_seen = 0;
        repeat (3) press(6);
        check_val("step_pulses", 32'(en_seen), 32'd3);
        check_val("step_pc",     32'(pc),      32'd3);
        check_val("step_halted", 32'(halted),  32'd1);
        step_btnN = 1'b0;
        repeat (3) cycle();
        step_btnN = 1'b1;
        repeat (10) cycle();
        check_val("glitch_en", 32'(en_seen), 32'd3);
        check_val("glitch_pc", 32'(pc),      32'd3);

        // Reset in the middle of a run.
        do_reset(1'b1);
        k = 0;
        while (pc != 12'h007 && k < 20) begin cycle(); k++; end
        check_val("mid_pc",    32'(pc),     32'h007);
        check_val("mid_en_on", 32'(cpu_en), 32'd1);
        do_reset(1'b1);
        #1;
        check_val("post_rst_state", 32'(state_o), 32'(M_RUN));
        repeat (3) cycle();

        // Breakpoint on the final PC: DONE wins, presses are ignored.
        do_reset(1'b1);
        bp_enable = 1'b1; bp_addr = FPC;
        run_until_finished(40);
        check_val("bpf_state", 32'(state_o), 32'(M_DONE));
        press(6);
        check_val("bpf_after_press", 32'(state_o),     32'(M_DONE));
        check_val("bpf_pc",          32'(pc),          32'h00F);
        check_val("bpf_count",       32'(instr_count), 32'd15);

        // Randomized traffic with branching PC so the counter saturates.
        branch_en = 1;
        do_reset(1'b1);
        bp_enable = 1'b0;
        run_left = 3;
        done_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                step_btnN = ~step_btnN;
                run_left = $urandom_range(1, 9);
            end
            run_left--;
            if ($urandom_range(0, 39) == 0) mode_run = ~mode_run;
            if ($urandom_range(0, 49) == 0) begin
                bp_enable = 1'($urandom_range(0, 1));
                bp_addr = 12'($urandom_range(0, 15));
            end
            if (m_state == M_DONE) done_cnt++;
            if (done_cnt > 12 || $urandom_range(0, 399) == 0) begin
                done_cnt = 0;
                do_reset(1'($urandom_range(0, 1)));
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
